// File: rtl/move_validator.sv
// Chess move legality checker: captures one request, checks turn/colour/geometry/rights,
// walks the path between src and dst one square per cycle, and optionally commits game state.
module move_validator #(
  parameter int unsigned N  = 8,
  parameter int unsigned PW = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N*N*PW-1:0]      board_in,
  input  logic [2*$clog2(N)-1:0] src_sq,
  input  logic [2*$clog2(N)-1:0] dst_sq,
  input  logic                   commit,
  input  logic                   move_valid,
  output logic                   move_ready,
  input  logic                   new_game,
  output logic                   result_valid,
  output logic                   allow_move,
  output logic [2:0]             reason,
  output logic                   side_to_move
);
  localparam int unsigned LW  = $clog2(N);
  localparam int unsigned SW  = 2*LW;
  localparam int unsigned BW  = N*N*PW;
  localparam int unsigned BIW = $clog2(BW);

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, WALK, DONE} state_e;
  typedef enum logic [2:0] {
    P_EMPTY = 3'd0, P_PAWN = 3'd1, P_KNIGHT = 3'd2, P_BISHOP = 3'd3,
    P_ROOK = 3'd4, P_QUEEN = 3'd5, P_KING = 3'd6
  } piece_e;
  typedef enum logic [2:0] {
    R_OK = 3'd0, R_SIDE = 3'd1, R_OWN = 3'd2, R_GEOM = 3'd3, R_BLOCK = 3'd4, R_RIGHT = 3'd5
  } reason_e;

  function automatic logic [PW-1:0] pc_at(input logic [BW-1:0] b, input logic [SW-1:0] sq);
    logic [BIW-1:0] base;
    base = BIW'(int'(sq) * int'(PW));
    return b[base +: PW];
  endfunction

  function automatic logic occ_at(input logic [BW-1:0] b, input logic [SW-1:0] sq);
    logic [BIW-1:0] base;
    base = BIW'(int'(sq) * int'(PW));
    return b[base +: 3] != P_EMPTY;
  endfunction

  // Castle-right bit invalidated by a square: {bK,bQ,wK,wQ}
  function automatic logic [3:0] corner_mask(input logic [SW-1:0] sq);
    logic [3:0] m;
    m = '0;
    if (sq[LW-1:0] == LW'(N-1)) begin
      if (sq[SW-1:LW] == '0)         m[0] = 1'b1;
      if (sq[SW-1:LW] == LW'(N-1))   m[1] = 1'b1;
    end
    if (sq[LW-1:0] == '0) begin
      if (sq[SW-1:LW] == '0)         m[2] = 1'b1;
      if (sq[SW-1:LW] == LW'(N-1))   m[3] = 1'b1;
    end
    return m;
  endfunction

  state_e            state_q, state_d;
  logic [BW-1:0]     board_q;
  logic [SW-1:0]     src_q, dst_q;
  logic              commit_q;
  logic [PW-1:0]     spc_q, dpc_q;
  logic signed [LW:0] df_q, dr_q;
  logic [LW-1:0]     cur_f_q, cur_r_q, stp_f_q, stp_r_q, walk_q;
  logic              allow_q;
  reason_e           reason_q;
  logic              side_q;
  logic [3:0]        rights_q;
  logic              ep_valid_q;
  logic [LW-1:0]     ep_file_q;

  logic              s_col, d_col, d_empty, fwd, kside;
  logic [2:0]        s_typ;
  logic [LW:0]       adf, adr;
  logic [LW-1:0]     s_file, s_row, home_row, rook_file, stp_f, stp_r;
  logic [PW-1:0]     rook_pc;
  reason_e           chk_reason;
  logic [LW-1:0]     chk_k;
  logic              walk_occ;
  logic [3:0]        rights_nx;

  always_comb begin
    s_col     = spc_q[PW-1];
    d_col     = dpc_q[PW-1];
    s_typ     = spc_q[2:0];
    d_empty   = dpc_q[2:0] == P_EMPTY;
    adf       = df_q[LW] ? -df_q : df_q;
    adr       = dr_q[LW] ? -dr_q : dr_q;
    fwd       = s_col ? (!dr_q[LW] && dr_q != 0) : dr_q[LW];
    s_file    = src_q[SW-1:LW];
    s_row     = src_q[LW-1:0];
    home_row  = s_col ? '0 : LW'(N-1);
    kside     = !df_q[LW];
    rook_file = kside ? LW'(N-1) : '0;
    rook_pc   = pc_at(board_q, {rook_file, home_row});
    stp_f     = (df_q == 0) ? '0 : (df_q[LW] ? '1 : LW'(1));
    stp_r     = (dr_q == 0) ? '0 : (dr_q[LW] ? '1 : LW'(1));
    chk_reason = R_OK;
    chk_k      = '0;
    if (s_typ == P_EMPTY || s_col != side_q) begin
      chk_reason = R_SIDE;
    end else if (!d_empty && d_col == s_col) begin
      chk_reason = R_OWN;
    end else begin
      case (s_typ)
        P_PAWN: begin
          if (adf == 0 && adr == 1 && fwd) begin
            if (!d_empty) chk_reason = R_GEOM;
          end else if (adf == 0 && adr == 2 && fwd && s_row == (s_col ? LW'(1) : LW'(N-2))) begin
            if (!d_empty) chk_reason = R_GEOM;
            chk_k = LW'(1);
          end else if (adf == 1 && adr == 1 && fwd) begin
            if (d_empty && !(ep_valid_q && dst_q[SW-1:LW] == ep_file_q &&
                             s_row == (s_col ? LW'(N-4) : LW'(3))))
              chk_reason = R_RIGHT;
          end else begin
            chk_reason = R_GEOM;
          end
        end
        P_KNIGHT: if (!((adf == 1 && adr == 2) || (adf == 2 && adr == 1))) chk_reason = R_GEOM;
        P_BISHOP: if (adf != adr) chk_reason = R_GEOM; else chk_k = LW'(adf - 1'b1);
        P_ROOK:   if (adf != 0 && adr != 0) chk_reason = R_GEOM; else chk_k = LW'(adf + adr - 1'b1);
        P_QUEEN: begin
          if (adf == adr)               chk_k = LW'(adf - 1'b1);
          else if (adf == 0 || adr == 0) chk_k = LW'(adf + adr - 1'b1);
          else                           chk_reason = R_GEOM;
        end
        P_KING: begin
          if (adf <= 1 && adr <= 1) begin
            chk_k = '0;
          end else if (adf == 2 && adr == 0 && s_row == home_row && s_file == LW'(N/2)) begin
            // Castling walks every square up to (not including) the rook.
            if (!rights_q[{s_col, kside}] || rook_pc[PW-1] != s_col || rook_pc[2:0] != P_ROOK)
              chk_reason = R_RIGHT;
            else
              chk_k = kside ? LW'(N/2-2) : LW'(N/2-1);
          end else begin
            chk_reason = R_GEOM;
          end
        end
        default: chk_reason = R_GEOM;
      endcase
    end
  end

  always_comb begin
    walk_occ  = occ_at(board_q, {cur_f_q, cur_r_q});
    rights_nx = rights_q & ~corner_mask(dst_q);
    if (spc_q[2:0] == P_ROOK) rights_nx = rights_nx & ~corner_mask(src_q);
    if (spc_q[2:0] == P_KING) rights_nx = rights_nx & (side_q ? 4'b0011 : 4'b1100);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (move_valid) state_d = FETCH;
      FETCH:   state_d = CHECK;
      CHECK:   state_d = (chk_reason != R_OK || chk_k == '0) ? DONE : WALK;
      WALK:    if (walk_occ || walk_q == LW'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (new_game) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_q    <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      commit_q   <= 1'b0;
      spc_q      <= '0;
      dpc_q      <= '0;
      df_q       <= '0;
      dr_q       <= '0;
      cur_f_q    <= '0;
      cur_r_q    <= '0;
      stp_f_q    <= '0;
      stp_r_q    <= '0;
      walk_q     <= '0;
      allow_q    <= 1'b0;
      reason_q   <= R_OK;
      side_q     <= 1'b0;
      rights_q   <= '1;
      ep_valid_q <= 1'b0;
      ep_file_q  <= '0;
    end else if (new_game) begin
      allow_q    <= 1'b0;
      reason_q   <= R_OK;
      side_q     <= 1'b0;
      rights_q   <= '1;
      ep_valid_q <= 1'b0;
      ep_file_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (move_valid) begin
          board_q  <= board_in;
          src_q    <= src_sq;
          dst_q    <= dst_sq;
          commit_q <= commit;
        end
        FETCH: begin
          spc_q <= pc_at(board_q, src_q);
          dpc_q <= pc_at(board_q, dst_q);
          df_q  <= $signed({1'b0, dst_q[SW-1:LW]}) - $signed({1'b0, src_q[SW-1:LW]});
          dr_q  <= $signed({1'b0, dst_q[LW-1:0]}) - $signed({1'b0, src_q[LW-1:0]});
        end
        CHECK: begin
          walk_q  <= chk_k;
          stp_f_q <= stp_f;
          stp_r_q <= stp_r;
          cur_f_q <= s_file + stp_f;
          cur_r_q <= s_row + stp_r;
          if (chk_reason != R_OK || chk_k == '0) begin
            allow_q  <= chk_reason == R_OK;
            reason_q <= chk_reason;
          end
        end
        WALK: begin
          cur_f_q <= cur_f_q + stp_f_q;
          cur_r_q <= cur_r_q + stp_r_q;
          walk_q  <= walk_q - 1'b1;
          if (walk_occ) begin
            allow_q  <= 1'b0;
            reason_q <= R_BLOCK;
          end else if (walk_q == LW'(1)) begin
            allow_q  <= 1'b1;
            reason_q <= R_OK;
          end
        end
        DONE: if (allow_q && commit_q) begin
          side_q   <= ~side_q;
          rights_q <= rights_nx;
          if (spc_q[2:0] == P_PAWN && adr == 2) begin
            ep_valid_q <= 1'b1;
            ep_file_q  <= src_q[SW-1:LW];
          end else begin
            ep_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign move_ready   = state_q == IDLE;
  assign result_valid = state_q == DONE;
  assign allow_move   = allow_q;
  assign reason       = reason_q;
  assign side_to_move = side_q;

endmodule

// File: tb/tb_move_validator.sv
// Directed bench for move_validator (8x8 board, 4-bit square codes).
module tb_move_validator;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] board_in = '0;
  logic [5:0]   src_sq = '0;
  logic [5:0]   dst_sq = '0;
  logic         commit = 1'b0;
  logic         move_valid = 1'b0;
  logic         new_game = 1'b0;
  logic         move_ready, result_valid, allow_move, side_to_move;
  logic [2:0]   reason;

  int checks = 0;
  int passed = 0;

  logic [255:0] sb, ep_b, kn, cs, bish;

  move_validator #(.N(8), .PW(4)) dut (
    .clk(clk), .rst_n(rst_n), .board_in(board_in), .src_sq(src_sq), .dst_sq(dst_sq),
    .commit(commit), .move_valid(move_valid), .move_ready(move_ready), .new_game(new_game),
    .result_valid(result_valid), .allow_move(allow_move), .reason(reason),
    .side_to_move(side_to_move)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic logic [255:0] put(input logic [255:0] b, input int sq, input logic [3:0] code);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = code;
    return r;
  endfunction

  // Square = file*8 + row; row 0 is black's home rank.
  function automatic logic [255:0] start_board();
    logic [255:0] b;
    logic [2:0]   back [8];
    back = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    b = '0;
    for (int f = 0; f < 8; f++) begin
      b = put(b, f*8 + 0, {1'b1, back[f]});
      b = put(b, f*8 + 1, 4'h9);
      b = put(b, f*8 + 6, 4'h1);
      b = put(b, f*8 + 7, {1'b0, back[f]});
    end
    return b;
  endfunction

  task automatic do_move(input string tag, input logic [255:0] b, input int s, input int d,
                         input logic cm, input int ex_lat, input logic ex_allow,
                         input int ex_reason, input logic ex_side);
    int lat;
    int guard;
    lat = 0;
    guard = 0;
    @(negedge clk);
    board_in = b; src_sq = 6'(s); dst_sq = 6'(d); commit = cm; move_valid = 1'b1;
    while (!move_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".ready"}, 32'(move_ready), 1);
    @(posedge clk);
    #1;
    move_valid = 1'b0; board_in = '0; src_sq = '0; dst_sq = '0; commit = 1'b0;
    do begin
      @(negedge clk);
      lat++;
    end while (!result_valid && lat < 30);
    chk({tag, ".lat"}, 32'(lat), 32'(ex_lat));
    chk({tag, ".allow"}, 32'(allow_move), 32'(ex_allow));
    chk({tag, ".reason"}, 32'(reason), 32'(ex_reason));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(result_valid), 0);
    chk({tag, ".side"}, 32'(side_to_move), 32'(ex_side));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first, second, seen;
    sb   = start_board();
    ep_b = put(put(put(sb, 54, 4'h0), 52, 4'h1), 44, 4'h9);
    kn   = put(put(put(put(256'b0, 48, 4'h2), 42, 4'h1), 39, 4'h6), 32, 4'hE);
    cs   = put(put(put(256'b0, 39, 4'h6), 63, 4'h4), 32, 4'hE);
    bish = put(put(put(256'b0, 7, 4'h3), 39, 4'h6), 32, 4'hE);

    #2;
    chk("rst.ready", 32'(move_ready), 1);
    chk("rst.rv", 32'(result_valid), 0);
    chk("rst.allow", 32'(allow_move), 0);
    chk("rst.reason", 32'(reason), 0);
    chk("rst.side", 32'(side_to_move), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // White double push file 6 (row 6 -> 4), one walked square
    do_move("dpush", sb, 54, 52, 1'b1, 4, 1'b1, 0, 1'b1);
    do_move("ep.ok", ep_b, 44, 53, 1'b0, 3, 1'b1, 0, 1'b1);
    do_move("ep.file", ep_b, 44, 37, 1'b0, 3, 1'b0, 5, 1'b1);
    do_move("wrongside", ep_b, 52, 51, 1'b0, 3, 1'b0, 1, 1'b1);
    do_move("bknight", sb, 8, 18, 1'b1, 3, 1'b1, 0, 1'b0);
    do_move("rookblk", sb, 63, 59, 1'b1, 4, 1'b0, 4, 1'b0);
    do_move("kn.own", kn, 48, 42, 1'b1, 3, 1'b0, 2, 1'b0);
    do_move("kn.ok", kn, 48, 58, 1'b0, 3, 1'b1, 0, 1'b0);
    do_move("kn.geom", kn, 48, 50, 1'b1, 3, 1'b0, 3, 1'b0);
    do_move("same", kn, 48, 48, 1'b1, 3, 1'b0, 2, 1'b0);

    // Request held through busy period
    @(negedge clk);
    board_in = kn; src_sq = 6'd48; dst_sq = 6'd58; commit = 1'b0; move_valid = 1'b1;
    @(posedge clk);
    first = 0; second = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) chk("held.busy", 32'(move_ready), 0);
      if (c == 4) chk("held.idle", 32'(move_ready), 1);
      if (result_valid) begin
        if (first == 0) first = c;
        else if (second == 0) begin
          second = c;
          move_valid = 1'b0;
        end
      end
    end
    move_valid = 1'b0;
    chk("held.first", 32'(first), 3);
    chk("held.second", 32'(second), 7);

    do_move("castle.ok", cs, 39, 55, 1'b0, 5, 1'b1, 0, 1'b0);
    do_move("castle.norook", cs, 39, 23, 1'b0, 3, 1'b0, 5, 1'b0);
    do_move("kstep", cs, 39, 47, 1'b1, 3, 1'b1, 0, 1'b1);
    do_move("bkstep", cs, 32, 40, 1'b1, 3, 1'b1, 0, 1'b0);
    do_move("castle.noright", cs, 39, 55, 1'b0, 3, 1'b0, 5, 1'b0);
    do_move("bishop", bish, 7, 56, 1'b0, 9, 1'b1, 0, 1'b0);

    // Reset asserted mid-walk of the 6-square bishop path
    @(negedge clk);
    board_in = bish; src_sq = 6'd7; dst_sq = 6'd56; commit = 1'b1; move_valid = 1'b1;
    @(posedge clk);
    #1;
    move_valid = 1'b0; commit = 1'b0;
    repeat (4) @(negedge clk);
    chk("rstw.busy", 32'(move_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("rstw.ready", 32'(move_ready), 1);
    chk("rstw.rv", 32'(result_valid), 0);
    chk("rstw.allow", 32'(allow_move), 0);
    chk("rstw.reason", 32'(reason), 0);
    chk("rstw.side", 32'(side_to_move), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    chk("rstw.noresult", 32'(seen), 0);
    chk("rstw.side2", 32'(side_to_move), 0);
    do_move("castle.restored", cs, 39, 55, 1'b0, 5, 1'b1, 0, 1'b0);

    // new_game overrides a same-cycle request and restores the side to move
    do_move("ng.pre", kn, 48, 58, 1'b1, 3, 1'b1, 0, 1'b1);
    @(negedge clk);
    new_game = 1'b1; board_in = sb; src_sq = 6'd9; dst_sq = 6'd10; move_valid = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0; move_valid = 1'b0;
    chk("ng.ready", 32'(move_ready), 1);
    chk("ng.side", 32'(side_to_move), 0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    chk("ng.noresult", 32'(seen), 0);

    // new_game aborts an in-flight walk
    @(negedge clk);
    board_in = bish; src_sq = 6'd7; dst_sq = 6'd56; commit = 1'b1; move_valid = 1'b1;
    @(posedge clk);
    #1;
    move_valid = 1'b0; commit = 1'b0;
    repeat (4) @(negedge clk);
    new_game = 1'b1;
    @(posedge clk);
    #1;
    new_game = 1'b0;
    chk("nga.ready", 32'(move_ready), 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1;
    end
    chk("nga.noresult", 32'(seen), 0);
    chk("nga.side", 32'(side_to_move), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
